// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment scan driver.
//   GLYPH_0..GLYPH_F : active-high segment patterns, bit order {a,b,c,d,e,f,g}
//   SEG_BLANK        : active-high "all segments off"
//   ssd_glyph()      : hex nibble -> active-high segment pattern
// ---------------------------------------------------------------------------
package ssd_pkg;

    localparam logic [6:0] GLYPH_0   = 7'b1111110;
    localparam logic [6:0] GLYPH_1   = 7'b0110000;
    localparam logic [6:0] GLYPH_2   = 7'b1101101;
    localparam logic [6:0] GLYPH_3   = 7'b1111001;
    localparam logic [6:0] GLYPH_4   = 7'b0110011;
    localparam logic [6:0] GLYPH_5   = 7'b1011011;
    localparam logic [6:0] GLYPH_6   = 7'b1011111;
    localparam logic [6:0] GLYPH_7   = 7'b1110000;
    localparam logic [6:0] GLYPH_8   = 7'b1111111;
    localparam logic [6:0] GLYPH_9   = 7'b1111011;
    localparam logic [6:0] GLYPH_A   = 7'b1110111;
    localparam logic [6:0] GLYPH_B   = 7'b0011111;
    localparam logic [6:0] GLYPH_C   = 7'b1001110;
    localparam logic [6:0] GLYPH_D   = 7'b0111101;
    localparam logic [6:0] GLYPH_E   = 7'b1001111;
    localparam logic [6:0] GLYPH_F   = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] ssd_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            4'hF:    g = GLYPH_F;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssd_scan_mux_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_mux_if
// Bundle between the register side (master) and the display driver (slave).
//   value[4*NDIG]  hex digits, digit 0 rightmost       (master -> slave)
//   dp_in[NDIG]    decimal point request per digit      (master -> slave)
//   blank_in[NDIG] force digit dark                     (master -> slave)
//   lz_en          leading-zero suppression enable      (master -> slave)
//   load           capture the above into pending       (master -> slave)
//   seg[7]/dp      segment bus {a..g} and decimal point (slave -> master)
//   an[NDIG]       digit anodes                         (slave -> master)
//   frame_start    one-cycle pulse at each frame start  (slave -> master)
// ---------------------------------------------------------------------------
interface ssd_scan_mux_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blank_in;
    logic              lz_en;
    logic              load;
    logic [6:0]        seg;
    logic              dp;
    logic [NDIG-1:0]   an;
    logic              frame_start;

    modport master (
        output value, dp_in, blank_in, lz_en, load,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  value, dp_in, blank_in, lz_en, load,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/ssd_hex_decode.sv
// ---------------------------------------------------------------------------
// ssd_hex_decode
// Combinational hex nibble to seven-segment decoder, active-high {a..g}.
// Output polarity is handled by the caller.
//   nib [4] in  : hex digit
//   seg [7] out : active-high segment pattern
// ---------------------------------------------------------------------------
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = ssd_glyph(nib);
endmodule

// File: rtl/ssd_scan_mux.sv
// ---------------------------------------------------------------------------
// ssd_scan_mux
// Multiplexed NDIG-digit seven-segment driver. Each digit owns a slot of
// REFRESH_DIV clocks; the first BLANK_CYC clocks of every slot keep all anodes
// off so the previous digit's segments cannot ghost onto the next anode.
// Display data goes load -> pending -> shadow, and shadow only changes at the
// frame wrap so a frame never mixes old and new values.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.slave  : value/dp_in/blank_in/lz_en/load in; seg/dp/an/frame_start out
// The NDIG of the connected interface must equal this module's NDIG.
// ---------------------------------------------------------------------------
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    ssd_scan_mux_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_TH = CW'(BLANK_CYC);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
    localparam logic            SEG_LOW  = (SEG_ACT_LOW != 0);
    localparam logic            AN_LOW   = (AN_ACT_LOW != 0);
    localparam logic [6:0]      SEG_OFF  = SEG_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF   = SEG_LOW;
    localparam logic [NDIG-1:0] AN_OFF   = AN_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              wrap;

    logic [4*NDIG-1:0] pend_value, shd_value;
    logic [NDIG-1:0]   pend_dp, shd_dp;
    logic [NDIG-1:0]   pend_blank, shd_blank;
    logic              pend_lz, shd_lz;

    logic [NDIG-1:0]   lz_dark;
    logic [3:0]        digit;
    logic              dark;
    logic              dp_req;
    logic              win;
    logic [NDIG-1:0]   an_hot;
    logic [6:0]        glyph;

    logic [6:0]        seg_q;
    logic              dp_q;
    logic [NDIG-1:0]   an_q;
    logic              fs_q;

    // Last cycle of the last slot: the next edge starts a new frame.
    assign wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pending always follows load. Shadow is refreshed only at the frame wrap;
    // a load on that same edge bypasses pending so it is not lost for a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lz    <= 1'b0;
            shd_value  <= '0;
            shd_dp     <= '0;
            shd_blank  <= '0;
            shd_lz     <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pend_lz    <= bus.lz_en;
            end
            if (wrap) begin
                if (bus.load) begin
                    shd_value <= bus.value;
                    shd_dp    <= bus.dp_in;
                    shd_blank <= bus.blank_in;
                    shd_lz    <= bus.lz_en;
                end else begin
                    shd_value <= pend_value;
                    shd_dp    <= pend_dp;
                    shd_blank <= pend_blank;
                    shd_lz    <= pend_lz;
                end
            end
        end
    end

    // Leading-zero mask: walk from the most significant digit down, tracking
    // whether every digit from here upward is zero. Digit 0 is always shown.
    always_comb begin
        logic zf;
        zf      = 1'b1;
        lz_dark = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zf         = zf & (shd_value[4*i +: 4] == 4'h0);
            lz_dark[i] = shd_lz && (i != 0) && zf;
        end
    end

    always_comb begin
        digit  = 4'h0;
        dark   = 1'b1;
        dp_req = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                digit  = shd_value[4*i +: 4];
                dark   = shd_blank[i] | lz_dark[i];
                dp_req = shd_dp[i];
            end
        end
    end

    // Anti-ghost window: anode may only turn on after BLANK_CYC cycles of the slot.
    assign win = (cnt >= BLANK_TH);

    always_comb begin
        an_hot = '0;
        for (int i = 0; i < NDIG; i++) begin
            an_hot[i] = (idx == IW'(i)) && win && !dark;
        end
    end

    ssd_hex_decode u_dec (
        .nib (digit),
        .seg (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
            fs_q  <= 1'b0;
        end else begin
            seg_q <= dark ? SEG_OFF : (SEG_LOW ? ~glyph : glyph);
            dp_q  <= (win && !dark && dp_req) ? ~DP_OFF : DP_OFF;
            an_q  <= an_hot ^ AN_OFF;
            fs_q  <= wrap;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_mux
// Directed bench for ssd_scan_mux with NDIG=4, REFRESH_DIV=8, BLANK_CYC=2,
// active-low segments and anodes. A frame is 32 clocks.
// ---------------------------------------------------------------------------
module tb_ssd_scan_mux;

    logic clk;
    logic rst;

    ssd_scan_mux_if #(.NDIG(4)) bus ();

    ssd_scan_mux #(
        .NDIG        (4),
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic [3:0]      blank_in;
        logic            lz;
        logic [3:0]      lit;     // expected lit digits
        logic [3:0][6:0] glyph;   // expected active-high glyph, [3] is leftmost
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance until frame_start is seen at a negedge (bounded).
    task automatic wait_fs();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.frame_start) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_fs: got no frame_start expected pulse within 40 cycles");
        end
    endtask

    task automatic load_inputs(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] b, input logic lz);
        bus.value    = v;
        bus.dp_in    = d;
        bus.blank_in = b;
        bus.lz_en    = lz;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    // Called right after frame_start was seen: checks the 32 output cycles of that frame.
    task automatic check_frame(input int v);
        int c, d;
        logic       lit;
        logic [6:0] g;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            c     = j % 8;
            d     = j / 8;
            lit   = vec[v].lit[d];
            g     = vec[v].glyph[d];
            e_an  = (c >= 2 && lit) ? ~(4'b0001 << d) : 4'hF;
            e_seg = lit ? ~g : 7'h7F;
            e_dp  = (c >= 2 && lit && vec[v].dp_in[d]) ? 1'b0 : 1'b1;
            chk($sformatf("vec%0d_d%0d_c%0d", v, d, c),
                {20'h0, bus.seg, bus.dp, bus.an}, {20'h0, e_seg, e_dp, e_an});
        end
    endtask

    initial begin
        int period;

        vec[0]  = '{value:16'h1234, dp_in:4'b0000, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h30, 7'h6D, 7'h79, 7'h33}};
        vec[1]  = '{value:16'h3210, dp_in:4'b0000, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h79, 7'h6D, 7'h30, 7'h7E}};
        vec[2]  = '{value:16'h7654, dp_in:4'b0000, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h70, 7'h5F, 7'h5B, 7'h33}};
        vec[3]  = '{value:16'hBA98, dp_in:4'b0000, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h1F, 7'h77, 7'h7B, 7'h7F}};
        vec[4]  = '{value:16'hFEDC, dp_in:4'b1111, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h47, 7'h4F, 7'h3D, 7'h4E}};
        vec[5]  = '{value:16'h0070, dp_in:4'b0000, blank_in:4'b0000, lz:1'b1, lit:4'b0011,
                    glyph:{7'h00, 7'h00, 7'h70, 7'h7E}};
        vec[6]  = '{value:16'h0000, dp_in:4'b0000, blank_in:4'b0000, lz:1'b1, lit:4'b0001,
                    glyph:{7'h00, 7'h00, 7'h00, 7'h7E}};
        vec[7]  = '{value:16'h0000, dp_in:4'b0000, blank_in:4'b0000, lz:1'b0, lit:4'b1111,
                    glyph:{7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vec[8]  = '{value:16'h0100, dp_in:4'b0000, blank_in:4'b0000, lz:1'b1, lit:4'b0111,
                    glyph:{7'h00, 7'h30, 7'h7E, 7'h7E}};
        vec[9]  = '{value:16'h1234, dp_in:4'b0100, blank_in:4'b0001, lz:1'b0, lit:4'b1110,
                    glyph:{7'h30, 7'h6D, 7'h79, 7'h00}};
        vec[10] = '{value:16'h0005, dp_in:4'b0001, blank_in:4'b0001, lz:1'b1, lit:4'b0000,
                    glyph:{7'h00, 7'h00, 7'h00, 7'h00}};

        rst          = 1'b1;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.lz_en    = 1'b0;
        bus.load     = 1'b0;

        // Reset state
        #3;
        chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
        chk("rst_dp",  {31'h0, bus.dp},  32'h1);
        chk("rst_an",  {28'h0, bus.an},  32'hF);
        chk("rst_fs",  {31'h0, bus.frame_start}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-slot with data loaded
        load_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_seg", {25'h0, bus.seg}, 32'h7F);
        chk("async_dp",  {31'h0, bus.dp},  32'h1);
        chk("async_an",  {28'h0, bus.an},  32'hF);
        chk("async_fs",  {31'h0, bus.frame_start}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_c0_an", {28'h0, bus.an}, 32'hF);
        @(negedge clk);
        chk("post_rst_c1_an", {28'h0, bus.an}, 32'hF);
        @(negedge clk);
        chk("post_rst_c2_an",  {28'h0, bus.an},  32'hE);
        chk("post_rst_c2_seg", {25'h0, bus.seg}, 32'h01);
        chk("post_rst_c2_fs",  {31'h0, bus.frame_start}, 32'h0);

        // frame_start period and width
        wait_fs();
        period = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            period++;
            if (bus.frame_start) break;
        end
        chk("fs_period", period, 32);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            load_inputs(vec[v].value, vec[v].dp_in, vec[v].blank_in, vec[v].lz);
            wait_fs();
            check_frame(v);
        end

        // Mid-frame load must not disturb the current frame
        load_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
        wait_fs();
        repeat (5) @(negedge clk);
        load_inputs(16'hBEEF, 4'h0, 4'h0, 1'b0);
        repeat (21) @(negedge clk);
        chk("midload_old_seg3", {25'h0, bus.seg}, {25'h0, ~7'h30});
        chk("midload_old_an3",  {28'h0, bus.an},  32'h7);
        wait_fs();
        repeat (3) @(negedge clk);
        chk("midload_new_seg0", {25'h0, bus.seg}, {25'h0, ~7'h47});
        chk("midload_new_an0",  {28'h0, bus.an},  32'hE);
        repeat (24) @(negedge clk);
        chk("midload_new_seg3", {25'h0, bus.seg}, {25'h0, ~7'h1F});

        // Load on the wrap edge takes effect in the frame it starts
        repeat (4) @(negedge clk);
        bus.value = 16'h0C0A;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("wrapload_fs", {31'h0, bus.frame_start}, 32'h1);
        repeat (3) @(negedge clk);
        chk("wrapload_seg0", {25'h0, bus.seg}, {25'h0, ~7'h77});
        chk("wrapload_an0",  {28'h0, bus.an},  32'hE);
        repeat (16) @(negedge clk);
        chk("wrapload_seg2", {25'h0, bus.seg}, {25'h0, ~7'h4E});
        chk("wrapload_an2",  {28'h0, bus.an},  32'hB);
        wait_fs();
        repeat (3) @(negedge clk);
        chk("wrapload_kept_seg0", {25'h0, bus.seg}, {25'h0, ~7'h77});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
